cmplx_mult_seq: RTL
===================

CMPLX_MULT_SEQ -- requirements
Module: cmplx_mult_seq

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-003 SHALL have port start, input, 1 bit: request a complex multiply; sampled only in IDLE.
REQ-004 SHALL have ports a_re, a_im, b_re, b_im, input, 16 bits each: operands, sign-magnitude Q7.8 (bit15 sign, bits14:8 integer, bits7:0 fraction).
REQ-005 SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-006 SHALL have port done, output, 1 bit: single-cycle pulse marking y_re/y_im/overflow valid.
REQ-007 SHALL have ports y_re, y_im, output, 16 bits each: result, sign-magnitude Q7.8, held until the next done.
REQ-008 SHALL have port overflow, output, 1 bit: result magnitude exceeded 0x7FFF in y_re or y_im.

Function
REQ-009 SHALL compute y = a*b: y_re = a_re*b_re - a_im*b_im, y_im = a_re*b_im + a_im*b_re.
REQ-010 SHALL instantiate exactly one team fixed-point multiplier (sign = XOR of sign bits, 15x15 magnitude product, keep product bits 22:8) and time-share it over four cycles.
REQ-011 SHALL use the FSM IDLE -> M0 -> M1 -> M2 -> M3 -> FIN -> IDLE; M0 = a_re*b_re, M1 = a_im*b_im, M2 = a_re*b_im, M3 = a_im*b_re.
REQ-012 SHALL leave IDLE for M0 on an edge where start=1; on that edge, operands are captured into internal registers; later operand changes SHALL have no effect.
REQ-013 SHALL advance one state per clock in M0..FIN unconditionally.
REQ-014 SHALL convert each product to 17-bit two's complement and accumulate: re_acc = p0 - p1, im_acc = p2 + p3; accumulators SHALL clear on start acceptance.
REQ-015 SHALL, on the FIN->IDLE edge, register y_re, y_im and overflow from the accumulators, and assert done for exactly one cycle.
REQ-016 Latency: start accepted at edge k; y valid and done=1 after edge k+5; next start accepted no earlier than edge k+6.
REQ-017 busy SHALL be 1 in states M0..FIN and 0 in IDLE.
REQ-018 start while not in IDLE SHALL be ignored with no queuing.
REQ-019 A zero-magnitude result SHALL be output with sign 0; 0x8000 SHALL never appear on y_re/y_im.
REQ-020 overflow SHALL be set if |re_acc| > 0x7FFF or |im_acc| > 0x7FFF, and SHALL update only at done.

Reset
REQ-021 While rst=1, the block SHALL hold: state IDLE, busy=0, done=0, y_re=0, y_im=0, overflow=0, accumulators 0.
REQ-022 rst asserted mid-operation SHALL abort it immediately and produce no done; the first start after release SHALL operate normally.

Configuration
REQ-023 Macro CMPLX_MULT_SEQ_SAT_EN defined: an out-of-range magnitude SHALL saturate to 0x7FFF with its sign kept.
REQ-024 Macro CMPLX_MULT_SEQ_SAT_EN undefined: an out-of-range magnitude SHALL wrap to its low 15 bits with its sign kept; overflow SHALL still be reported.

Verification
REQ-025 a=0x0100+j0x0100, b=0x0100+j0x0100, start pulse -> 5 cycles later done=1, y_re=0x0000, y_im=0x0200, overflow=0.
REQ-026 a=0x0200+j0x8300, b=0x8100+j0x0080 -> y_re=0x8080 (-0.5), y_im=0x0400 (4.0).
REQ-027 a=0x7F00+j0x7F00, b=0x0100+j0x0100 -> y_re=0x0000, overflow=1; y_im=0x7FFF with SAT_EN, 0x7E00 without.
REQ-028 a=0x0100+j0, b=0x8000+j0 -> y_re=0x0000 (not 0x8000), y_im=0x0000.
REQ-029 start held high for 10 cycles with changing operands -> one done per 6 cycles; each result matches the operands captured at its accepted start.
REQ-030 rst pulsed while in M2 -> busy=0 and y=0 immediately, no done; a new start afterwards yields the correct result 5 cycles later.

Source files
------------

// File: rtl/cmplx_mult_seq.sv
// Sequential complex multiplier on sign-magnitude Q7.8 operands, one shared multiplier over four cycles.
// Define CMPLX_MULT_SEQ_SAT_EN to saturate out-of-range magnitudes; otherwise they wrap to 15 bits.

module cmplx_mult_seq_fxmul (
   input  logic [15:0] a_i,
   input  logic [15:0] b_i,
   output logic [15:0] p_o
);
   logic [29:0] mag_full;
   logic        unused_mag;

   assign mag_full   = a_i[14:0] * b_i[14:0];
   assign p_o        = {a_i[15] ^ b_i[15], mag_full[22:8]};
   assign unused_mag = ^{mag_full[29:23], mag_full[7:0]};
endmodule

module cmplx_mult_seq (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] a_re,
   input  logic [15:0] a_im,
   input  logic [15:0] b_re,
   input  logic [15:0] b_im,
   output logic        busy,
   output logic        done,
   output logic [15:0] y_re,
   output logic [15:0] y_im,
   output logic        overflow
);
   typedef enum logic [2:0] {StIdle, StM0, StM1, StM2, StM3, StFin} state_e;

   state_e      state_q, state_d;
   logic [15:0] ar_q, ar_d, ai_q, ai_d, br_q, br_d, bi_q, bi_d;
   logic [16:0] re_acc_q, re_acc_d, im_acc_q, im_acc_d;
   logic [15:0] y_re_q, y_re_d, y_im_q, y_im_d;
   logic        ovf_q, ovf_d, done_q, done_d;

   logic        accept;
   logic [15:0] mul_a, mul_b, prod;
   logic [16:0] prod_mag, prod_s;
   logic [16:0] re_pack, im_pack;

   // Returns {overflow, sign-magnitude result}; a zero magnitude always gets sign 0.
   function automatic logic [16:0] pack_res(input logic [16:0] acc);
      logic [16:0] mag;
      logic [14:0] m15;
      logic        big;
      mag = acc[16] ? (17'd0 - acc) : acc;
      big = |mag[16:15];
`ifdef CMPLX_MULT_SEQ_SAT_EN
      m15 = big ? 15'h7FFF : mag[14:0];
`else
      m15 = mag[14:0];
`endif
      return {big, acc[16] && (m15 != 15'd0), m15};
   endfunction

   cmplx_mult_seq_fxmul u_mul (
      .a_i (mul_a),
      .b_i (mul_b),
      .p_o (prod)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         ar_q     <= '0;
         ai_q     <= '0;
         br_q     <= '0;
         bi_q     <= '0;
         re_acc_q <= '0;
         im_acc_q <= '0;
         y_re_q   <= '0;
         y_im_q   <= '0;
         ovf_q    <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         ar_q     <= ar_d;
         ai_q     <= ai_d;
         br_q     <= br_d;
         bi_q     <= bi_d;
         re_acc_q <= re_acc_d;
         im_acc_q <= im_acc_d;
         y_re_q   <= y_re_d;
         y_im_q   <= y_im_d;
         ovf_q    <= ovf_d;
         done_q   <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start) state_d = StM0;
         StM0:    state_d = StM1;
         StM1:    state_d = StM2;
         StM2:    state_d = StM3;
         StM3:    state_d = StFin;
         StFin:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      busy   = (state_q != StIdle);
      accept = (state_q == StIdle) && start;
      mul_a  = ar_q;
      mul_b  = br_q;
      unique case (state_q)
         StM1:    begin mul_a = ai_q; mul_b = bi_q; end
         StM2:    begin mul_a = ar_q; mul_b = bi_q; end
         StM3:    begin mul_a = ai_q; mul_b = br_q; end
         default: begin mul_a = ar_q; mul_b = br_q; end
      endcase
   end

   assign prod_mag = {2'b00, prod[14:0]};
   assign prod_s   = prod[15] ? (17'd0 - prod_mag) : prod_mag;
   assign re_pack  = pack_res(re_acc_q);
   assign im_pack  = pack_res(im_acc_q);

   always_comb begin
      ar_d     = ar_q;
      ai_d     = ai_q;
      br_d     = br_q;
      bi_d     = bi_q;
      re_acc_d = re_acc_q;
      im_acc_d = im_acc_q;
      if (accept) begin
         ar_d     = a_re;
         ai_d     = a_im;
         br_d     = b_re;
         bi_d     = b_im;
         re_acc_d = '0;
         im_acc_d = '0;
      end
      unique case (state_q)
         StM0:    re_acc_d = re_acc_q + prod_s;
         StM1:    re_acc_d = re_acc_q - prod_s;
         StM2:    im_acc_d = im_acc_q + prod_s;
         StM3:    im_acc_d = im_acc_q + prod_s;
         default: ;
      endcase
   end

   always_comb begin
      y_re_d = y_re_q;
      y_im_d = y_im_q;
      ovf_d  = ovf_q;
      done_d = (state_q == StFin);
      if (state_q == StFin) begin
         y_re_d = re_pack[15:0];
         y_im_d = im_pack[15:0];
         ovf_d  = re_pack[16] | im_pack[16];
      end
   end

   assign done     = done_q;
   assign y_re     = y_re_q;
   assign y_im     = y_im_q;
   assign overflow = ovf_q;
endmodule
